// File: rtl/ysyx_22040237_pkg.sv
// Shared definitions for the ysyx_22040237 instruction fetch unit.
//   IFU_RESET_PC : default first fetch address after reset
//   INST_BYTES   : sequential fetch stride
//   ifu_state_e  : fetch FSM state encoding
//   jump_target  : clears bit 0 of a redirect target
package ysyx_22040237_pkg;

  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [63:0] INST_BYTES   = 64'd4;

  typedef enum logic [2:0] {
    IFU_RST  = 3'd0,
    IFU_REQ  = 3'd1,
    IFU_WAIT = 3'd2,
    IFU_HOLD = 3'd3,
    IFU_ERR  = 3'd4
  } ifu_state_e;

  // Redirect targets are always halfword aligned: bit 0 is dropped.
  function automatic logic [63:0] jump_target(input logic [63:0] addr);
    return addr & ~64'h1;
  endfunction

endpackage

// File: rtl/ysyx_22040237_ifu_pc.sv
// PC register and next-PC selection for the fetch unit.
//   clk, rst          : clock, asynchronous active-low reset
//   update_i          : instruction handshake, advances the PC
//   jump_flag_i       : take the redirect target instead of PC+4
//   jump_addr_i       : redirect target
//   pc_o              : current fetch PC
//   next_misalign_o   : the candidate next PC has bit 1 set
// Optional macro YSYX_22040237_IFU_MISALIGN_CHK_EN: when defined, a target
// with bit 1 set is reported through next_misalign_o; otherwise bit 1 is
// cleared and next_misalign_o is tied low.
module ysyx_22040237_ifu_pc
  import ysyx_22040237_pkg::*;
#(
  parameter logic [63:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update_i,
  input  logic        jump_flag_i,
  input  logic [63:0] jump_addr_i,
  output logic [63:0] pc_o,
  output logic        next_misalign_o
);

  logic [63:0] pc_q;
  logic [63:0] pc_d;
  logic [63:0] next_pc;

  always_comb begin
    // NOTE: every variable of a combinational block gets a value on every
    // path first, otherwise synthesis infers a latch.
    next_pc = jump_flag_i ? jump_target(jump_addr_i) : pc_q + INST_BYTES;
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
    next_misalign_o = next_pc[1];
`else
    next_pc[1]      = 1'b0;
    next_misalign_o = 1'b0;
`endif
    pc_d = update_i ? next_pc : pc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: issues one fetch at a time to instruction memory,
// holds the returned word for the decoder and advances/redirects the PC on
// the decoder handshake.
//   clk, rst                    : clock, asynchronous active-low reset
//   pc_jump_flag_i/addr_i       : redirect from exu, used only on handshake
//   imem_req_valid_o/ready_i    : fetch request handshake
//   imem_req_addr_o             : fetch address (current PC)
//   imem_rsp_valid_i/data_i     : fetch response, accepted only in WAIT
//   inst_valid_o/ready_i        : instruction handshake towards idu
//   inst_o, inst_pc_o           : held instruction and its PC
//   misalign_o                  : sticky misaligned-target flag
// Optional macro YSYX_22040237_IFU_MISALIGN_CHK_EN enables the misaligned
// target check and the ERR state; without it misalign_o is tied low.
module ysyx_22040237_ifu
  import ysyx_22040237_pkg::*;
#(
  parameter logic [63:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_jump_flag_i,
  input  logic [63:0] pc_jump_addr_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [63:0] inst_pc_o,
  output logic        misalign_o
);

  ifu_state_e  state_q;
  logic        req_valid_q;
  logic        inst_valid_q;
  logic [31:0] inst_q;
  logic [63:0] inst_pc_q;
  logic [63:0] pc;
  logic        tgt_misalign;
  logic        req_hs;
  logic        inst_hs;

  assign req_hs  = req_valid_q & imem_req_ready_i;
  assign inst_hs = inst_valid_q & inst_ready_i;

  ysyx_22040237_ifu_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk             (clk),
    .rst             (rst),
    .update_i        (inst_hs),
    .jump_flag_i     (pc_jump_flag_i),
    .jump_addr_i     (pc_jump_addr_i),
    .pc_o            (pc),
    .next_misalign_o (tgt_misalign)
  );

`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
  logic misalign_q;
`endif

  // Valid outputs are registered alongside the state so they change only
  // on the edge that enters/leaves REQ or HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IFU_RST;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IFU_RST: begin
          state_q     <= IFU_REQ;
          req_valid_q <= 1'b1;
        end
        IFU_REQ: begin
          if (req_hs) begin
            state_q     <= IFU_WAIT;
            req_valid_q <= 1'b0;
          end
        end
        IFU_WAIT: begin
          // Responses are only meaningful here; any other state drops them.
          if (imem_rsp_valid_i) begin
            state_q      <= IFU_HOLD;
            inst_q       <= imem_rsp_data_i;
            inst_pc_q    <= pc;
            inst_valid_q <= 1'b1;
          end
        end
        IFU_HOLD: begin
          if (inst_hs) begin
            inst_valid_q <= 1'b0;
            if (tgt_misalign) begin
              state_q    <= IFU_ERR;
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
              misalign_q <= 1'b1;
`endif
            end else begin
              state_q     <= IFU_REQ;
              req_valid_q <= 1'b1;
            end
          end
        end
        IFU_ERR: begin
          state_q <= IFU_ERR;
        end
        default: begin
          state_q      <= IFU_RST;
          req_valid_q  <= 1'b0;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid_o = req_valid_q;
  assign imem_req_addr_o  = pc;
  assign inst_valid_o     = inst_valid_q;
  assign inst_o           = inst_q;
  assign inst_pc_o        = inst_pc_q;

`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule
